fifo_stream_drain: RTL and testbench
====================================

# fifo_stream_drain

- Sits directly downstream of the synchronous FIFO and drains it into a valid/ready stream.
- Issues FIFO read strobes, absorbs the FIFO's one-cycle registered read latency in a 3-entry skid buffer, and presents words in order with full throughput under back-pressure.
- Provides run/drain control, a delivered-word counter and a sticky error flag for FIFO underflow.

## Interface
Parameters:
- DATA_WIDTH, 16, width of FIFO data and stream data.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; shared with the FIFO.
- en  in  1  level; 1 = run (issue reads), 0 = drain (stop reads, flush buffer).
- fifo_empty  in  1  FIFO empty flag (combinational from FIFO count).
- fifo_data_out  in  DATA_WIDTH  FIFO registered read data.
- fifo_underflow  in  1  FIFO underflow flag.
- fifo_rd_en  out  1  read strobe to the FIFO.
- m_data  out  DATA_WIDTH  stream data (head of buffer).
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- busy  out  1  1 while not IDLE or the buffer is non-empty.
- word_cnt  out  CNT_WIDTH  words accepted downstream (m_valid & m_ready), wraps modulo 2^CNT_WIDTH.
- err  out  1  sticky; set when fifo_underflow is seen.

## Operation
- State machine, states IDLE, RUN, DRAIN:
  - IDLE -> RUN when en=1.
  - RUN -> DRAIN when en=0.
  - DRAIN -> RUN when en=1.
  - DRAIN -> IDLE when inflight=0 and buf_cnt=0.
- inflight (1 bit) is set in the cycle after fifo_rd_en=1. On the following edge fifo_data_out is written into the buffer tail.
- fifo_rd_en = (state==RUN) & !fifo_empty & (buf_cnt + inflight < 3).
  - Driven combinationally from registered state and fifo_empty only; there is no path from m_ready.
  - fifo_rd_en is never asserted while fifo_empty=1, so the adapter never causes underflow.
- The buffer is a 3-entry circular store with head/tail pointers wrapping 2->0 and buf_cnt 0..3.
  - Push and pop in the same cycle leave buf_cnt unchanged.
  - A push is never attempted with buf_cnt=3; the credit rule guarantees this.
- m_valid = (buf_cnt != 0); m_data = entry at head. Both are held stable while m_valid & !m_ready.
- word_cnt increments on each m_valid & m_ready.
- err sets on fifo_underflow=1 and clears only on reset.
- busy = (state != IDLE) | (buf_cnt != 0).

## Timing
- Reset values:
  - fifo_rd_en=0, m_valid=0, m_data=0, busy=0, word_cnt=0, err=0.
  - state=IDLE, inflight=0, buf_cnt=0, pointers=0.
- Latency:
  - fifo_rd_en high in cycle t -> fifo_data_out valid in t+1 -> m_valid high in t+2 if the buffer was empty.
  - The FIFO-to-stream path is therefore 2 cycles.
- Throughput: with m_ready=1 and the FIFO non-empty, one word per cycle sustained (steady state buf_cnt=1, inflight=1).
- Back-pressure: with m_ready=0, at most 3 words are captured, after which fifo_rd_en stays 0 and no data is lost.
- en falling while a read is in flight: that word is still captured and delivered in DRAIN.
- FIFO reaching count 1: one read is issued; fifo_empty goes 1 the next cycle and reads stop.
- Asynchronous reset mid-transfer: all state clears immediately and buffered or in-flight words are discarded. The FIFO is reset by the same rst_n.

## Structure
- Shared package fifo_pkg holds:
  - state typedef drain_state_e {IDLE, RUN, DRAIN};
  - constant SKID_DEPTH=3;
  - default DATA_WIDTH.
- One sub-module, skid_buf3: the 3-entry circular buffer with push/pop, count, and head data. The FSM, credit logic and counter stay in the top.

## Test plan
- FIFO preloaded with 0x0001..0x0008, en=1, m_ready=1 -> m_data 0x0001..0x0008 on 8 consecutive cycles starting 2 cycles after the first fifo_rd_en; word_cnt=8; err=0.
- Same preload, m_ready=0 for 10 cycles -> exactly 3 fifo_rd_en pulses, m_data held at 0x0001; after m_ready=1, all 8 words arrive in order.
- Empty FIFO, en=1 -> fifo_rd_en never asserted, m_valid=0, no FIFO underflow.
- en dropped 1 cycle after a fifo_rd_en with m_ready=1 -> in-flight word delivered, no further reads, state reaches IDLE, busy=0.
- rst_n pulsed low with buf_cnt=2 -> m_valid, busy, word_cnt, err all 0 asynchronously; normal operation resumes after release.
- fifo_underflow forced high 1 cycle -> err=1 and stays 1 until reset; CNT_WIDTH=4 with 17 words -> word_cnt wraps to 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and constants for the FIFO stream drain adapter
package fifo_pkg;

    localparam int SKID_DEPTH         = 3;
    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } drain_state_e;

    // Circular pointer advance over the SKID_DEPTH entries.
    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == 2'(SKID_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/skid_buf3.sv
// rtl/skid_buf3.sv - 3-entry circular skid buffer with push/pop, count and head data
module skid_buf3
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            cnt,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
    logic [1:0]            head_q, head_d;
    logic [1:0]            tail_q, tail_d;
    logic [1:0]            cnt_q, cnt_d;

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < SKID_DEPTH; i++) begin
            if (push && (tail_q == 2'(i))) begin
                mem_d[i] = push_data;
            end
        end
        if (push) begin
            tail_d = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q <= 2'd0;
            tail_q <= 2'd0;
            cnt_q  <= 2'd0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        case (head_q)
            2'd1:    head_data = mem_q[1];
            2'd2:    head_data = mem_q[2];
            default: head_data = mem_q[0];
        endcase
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fifo_stream_drain.sv
// rtl/fifo_stream_drain.sv - drains a synchronous FIFO into a valid/ready stream
module fifo_stream_drain
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  err
);

    drain_state_e          state_q, state_d;
    logic                  inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    logic                  err_q, err_d;
    logic [1:0]            buf_cnt;
    logic                  credit_ok;
    logic                  pop;

    // A read is only issued when the word it returns is guaranteed a free slot.
    assign credit_ok  = ({1'b0, buf_cnt} + {2'b00, inflight_q}) < 3'(SKID_DEPTH);
    assign fifo_rd_en = (state_q == RUN) && !fifo_empty && credit_ok;
    assign m_valid    = (buf_cnt != 2'd0);
    assign pop        = m_valid && m_ready;

    always_comb begin
        state_d    = state_q;
        inflight_d = fifo_rd_en;
        word_cnt_d = pop ? word_cnt_q + CNT_WIDTH'(1) : word_cnt_q;
        err_d      = err_q || fifo_underflow;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = DRAIN;
            DRAIN: begin
                if (en) begin
                    state_d = RUN;
                end else if (!inflight_q && (buf_cnt == 2'd0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            word_cnt_q <= word_cnt_d;
            err_q      <= err_d;
        end
    end

    skid_buf3 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (fifo_data_out),
        .pop       (pop),
        .cnt       (buf_cnt),
        .head_data (m_data)
    );

    assign busy     = (state_q != IDLE) || (buf_cnt != 2'd0);
    assign word_cnt = word_cnt_q;
    assign err      = err_q;

endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb/tb_fifo_stream_drain.sv - directed self-checking bench for fifo_stream_drain
module tb_fifo_stream_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        fifo_empty;
    logic [15:0] fifo_data_out;
    logic        fifo_underflow;
    logic        fifo_rd_en;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic [3:0]  word_cnt;
    logic        err;

    logic        wr;
    logic [15:0] wr_data;
    logic        force_uf;
    logic [15:0] fmem [0:31];
    logic [4:0]  frp, fwp;
    logic [5:0]  fcnt;
    logic        model_uf_q;
    int          uf_seen = 0;

    int passes = 0;
    int total  = 0;

    int rd_pulses, ndel, t_rd, first_del, last_del, consec_ok, held_bad;
    logic [15:0] del_data;

    always #5 clk = ~clk;

    fifo_stream_drain #(
        .DATA_WIDTH (16),
        .CNT_WIDTH  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .fifo_empty     (fifo_empty),
        .fifo_data_out  (fifo_data_out),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .busy           (busy),
        .word_cnt       (word_cnt),
        .err            (err)
    );

    // Behavioural synchronous FIFO with registered read data.
    assign fifo_empty     = (fcnt == 6'd0);
    assign fifo_underflow = model_uf_q | force_uf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frp           <= 5'd0;
            fwp           <= 5'd0;
            fcnt          <= 6'd0;
            fifo_data_out <= 16'd0;
            model_uf_q    <= 1'b0;
        end else begin
            if (wr) begin
                fmem[fwp] <= wr_data;
                fwp       <= fwp + 5'd1;
            end
            if (fifo_rd_en && fcnt != 6'd0) begin
                fifo_data_out <= fmem[frp];
                frp           <= frp + 5'd1;
            end
            fcnt       <= fcnt + {5'd0, wr} - {5'd0, (fifo_rd_en && fcnt != 6'd0)};
            model_uf_q <= fifo_rd_en && (fcnt == 6'd0);
        end
    end

    always @(posedge clk) begin
        if (model_uf_q) uf_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic preload(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            wr_data = 16'(base + i);
            wr      = 1'b1;
            step();
        end
        wr = 1'b0;
    endtask

    task automatic collect(input int n, input int base, input string tag);
        int got = 0;
        for (int c = 0; c < 100 && got < n; c++) begin
            if (m_valid && m_ready) begin
                check(tag, 32'(m_data), 32'(base + got));
                got++;
            end
            step();
        end
        check({tag, "_count"}, 32'(got), 32'(n));
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (busy && c < 50) begin
            step();
            c++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic sample_t4();
        if (fifo_rd_en) rd_pulses++;
        if (m_valid && m_ready) begin
            del_data = m_data;
            ndel++;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        m_ready  = 1'b0;
        wr       = 1'b0;
        wr_data  = 16'd0;
        force_uf = 1'b0;
        #1;
        check("rst_rd_en",    32'(fifo_rd_en), 32'd0);
        check("rst_m_valid",  32'(m_valid),    32'd0);
        check("rst_m_data",   32'(m_data),     32'd0);
        check("rst_busy",     32'(busy),       32'd0);
        check("rst_word_cnt", 32'(word_cnt),   32'd0);
        check("rst_err",      32'(err),        32'd0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Full throughput: 8 words back to back, 2-cycle latency.
        preload(8, 1);
        en = 1'b1;
        m_ready = 1'b1;
        rd_pulses = 0; ndel = 0; t_rd = -1; first_del = -1; last_del = -1; consec_ok = 1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (fifo_rd_en) begin
                rd_pulses++;
                if (t_rd < 0) t_rd = c;
            end
            if (m_valid && m_ready) begin
                check("t1_data", 32'(m_data), 32'(ndel + 1));
                if (first_del < 0) first_del = c;
                else if (c != last_del + 1) consec_ok = 0;
                last_del = c;
                ndel++;
            end
        end
        check("t1_latency",  32'(first_del), 32'(t_rd + 2));
        check("t1_ndel",     32'(ndel),      32'd8);
        check("t1_consec",   32'(consec_ok), 32'd1);
        check("t1_rd_pulse", 32'(rd_pulses), 32'd8);
        check("t1_word_cnt", 32'(word_cnt),  32'd8);
        check("t1_err",      32'(err),       32'd0);
        en = 1'b0;
        wait_idle("t1_idle");

        // Back-pressure: only 3 reads while stalled, head held.
        preload(8, 1);
        m_ready = 1'b0;
        en = 1'b1;
        rd_pulses = 0; held_bad = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (fifo_rd_en) rd_pulses++;
            if (m_valid && m_data !== 16'h0001) held_bad++;
        end
        check("t2_rd_pulse", 32'(rd_pulses), 32'd3);
        check("t2_m_valid",  32'(m_valid),   32'd1);
        check("t2_m_data",   32'(m_data),    32'h0001);
        check("t2_held",     32'(held_bad),  32'd0);
        m_ready = 1'b1;
        collect(8, 1, "t2_data");
        check("t2_word_cnt", 32'(word_cnt), 32'd0);

        // Empty FIFO while running: no reads, no valid, no underflow.
        rd_pulses = 0; held_bad = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (fifo_rd_en) rd_pulses++;
            if (m_valid) held_bad++;
        end
        check("t3_rd_pulse", 32'(rd_pulses), 32'd0);
        check("t3_m_valid",  32'(held_bad),  32'd0);
        check("t3_underflow", 32'(uf_seen),  32'd0);
        check("t3_err",      32'(err),       32'd0);

        // en dropped right after a read: in-flight word still delivered.
        rd_pulses = 0; ndel = 0; del_data = 16'd0;
        wr_data = 16'h00A1;
        wr = 1'b1;
        step();
        check("t4_first_rd", 32'(fifo_rd_en), 32'd1);
        en = 1'b0;
        wr_data = 16'h00A2;
        step();
        sample_t4();
        wr_data = 16'h00A3;
        step();
        wr = 1'b0;
        for (int c = 0; c < 20; c++) begin
            sample_t4();
            step();
        end
        check("t4_rd_after", 32'(rd_pulses), 32'd0);
        check("t4_ndel",     32'(ndel),      32'd1);
        check("t4_data",     32'(del_data),  32'h00A1);
        check("t4_word_cnt", 32'(word_cnt),  32'd1);
        wait_idle("t4_idle");

        // Sticky error.
        force_uf = 1'b1;
        step();
        force_uf = 1'b0;
        step();
        check("t5_err_set", 32'(err), 32'd1);
        step(); step(); step();
        check("t5_err_hold", 32'(err), 32'd1);

        // Async reset with two words buffered.
        m_ready = 1'b0;
        en = 1'b1;
        for (int c = 0; c < 6; c++) step();
        check("t6_pre_valid", 32'(m_valid), 32'd1);
        check("t6_pre_data",  32'(m_data),  32'h00A2);
        check("t6_pre_busy",  32'(busy),    32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid",    32'(m_valid),    32'd0);
        check("t6_rst_busy",     32'(busy),       32'd0);
        check("t6_rst_word_cnt", 32'(word_cnt),   32'd0);
        check("t6_rst_err",      32'(err),        32'd0);
        check("t6_rst_data",     32'(m_data),     32'd0);
        check("t6_rst_rd_en",    32'(fifo_rd_en), 32'd0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Resume after reset; 17 words wrap the 4-bit counter to 1.
        preload(17, 16'h0100);
        en = 1'b1;
        m_ready = 1'b1;
        collect(17, 16'h0100, "t7_data");
        check("t7_word_cnt",  32'(word_cnt), 32'd1);
        check("t7_err",       32'(err),      32'd0);
        check("t7_underflow", 32'(uf_seen),  32'd0);
        en = 1'b0;
        wait_idle("t7_idle");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
